useq_loader: RTL

//  Owns the useq program memory and sequences the core's life cycle. Holds the useq in

---
 rtl/useq_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/useq_loader.sv
// useq program loader: receives a framed byte stream into program RAM,
// verifies the checksum, then releases the core and serves its fetches.
module useq_loader #(
  parameter int ADDR_W        = 8,
  parameter int RELEASE_DELAY = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              host_start_i,
  input  logic              host_valid_i,
  input  logic [7:0]        host_data_i,
  output logic              host_ready_o,
  input  logic [ADDR_W-1:0] core_addr_i,
  output logic [7:0]        core_data_o,
  output logic              core_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_cksum_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CKSUM,
    S_HOLD,
    S_RUN
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [7:0]        sum_q;
  logic [7:0]        timer_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              rstn_q;
  logic              err_q;

  logic [7:0]        mem [DEPTH];

  logic              accept;
  logic [7:0]        sum_d;

  // host_start wins over a byte offered in the same cycle
  assign accept = host_valid_i & ready_q & ~host_start_i;
  assign sum_d  = sum_q + host_data_i;

  assign host_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign core_rst_n_o = rstn_q;
  assign err_cksum_o  = err_q;
  assign core_data_o  = mem[core_addr_i];

  always_ff @(posedge clk_i) begin
    if (state_q == S_DATA && accept) begin
      mem[ptr_q] <= host_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      timer_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rstn_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (host_start_i) begin
      state_q <= S_LEN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      timer_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      rstn_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_LEN: begin
          if (accept) begin
            // a length byte of zero means a full RAM image
            cnt_q   <= (host_data_i == 8'd0) ?
                       (ADDR_W+1)'(DEPTH) :
                       (ADDR_W+1)'(host_data_i);
            ptr_q   <= '0;
            sum_q   <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            sum_q <= sum_d;
            cnt_q <= cnt_q - (ADDR_W+1)'(1);
            if (cnt_q == (ADDR_W+1)'(1)) begin
              state_q <= S_CKSUM;
            end
          end
        end
        S_CKSUM: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (sum_d == 8'd0) begin
              state_q <= S_HOLD;
              timer_q <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          timer_q <= timer_q + 8'd1;
          if (timer_q == 8'(RELEASE_DELAY - 1)) begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rstn_q  <= 1'b1;
          end
        end
        S_RUN: ;
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          rstn_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
